mac_result_drain: RTL and testbench
===================================

// Module: mac_result_drain
// PURPOSE
//  Reads out the mac_array accumulator vector at the end of a compute pass.
//  Snapshots all ARRAY_SIZE accumulators on a capture pulse.
//  Requantizes each lane by arithmetic right shift plus signed saturation.
//  Streams lanes out one per handshake (valid/ready) in index order, so the
//  array can start its next pass while results drain.
// PARAMETERS
//  ARRAY_SIZE             2   number of accumulator lanes (>=1)
//  ACCUMULATOR_DATA_WIDTH 16  width of each accumulator, signed two's complement
//  OUT_DATA_WIDTH         8   width of each output word, signed (<= ACCUMULATOR_DATA_WIDTH)
//  SHIFT                  0   arithmetic right shift applied before saturation (< ACCUMULATOR_DATA_WIDTH)
// PORTS
//  clk             in   1                          clock, rising edge
//  rst             in   1                          asynchronous, active-high reset
//  capture         in   1                          one-cycle pulse: snapshot acc_in and start a drain
//  acc_in          in   ACCUMULATOR_DATA_WIDTH x ARRAY_SIZE  accumulator vector from mac_array
//  acc_clear       out  1                          one-cycle pulse after an accepted capture (clears mac_array)
//  busy            out  1                          drain in progress
//  capture_dropped out  1                          one-cycle pulse: a capture was ignored
//  out_valid       out  1                          out_data/out_index/out_last are valid
//  out_ready       in   1                          downstream accepts the word
//  out_data        out  OUT_DATA_WIDTH             requantized lane value
//  out_index       out  $clog2(ARRAY_SIZE) (min 1) lane number of out_data
//  out_last        out  1                          high with the word for lane ARRAY_SIZE-1
// BEHAVIOUR
//  Reset (async) values:
//   - state=IDLE; idx=0; shadow registers=0.
//   - out_valid=busy=acc_clear=capture_dropped=out_last=0; out_data=0; out_index=0.
//  FSM states are IDLE and DRAIN.
//  IDLE:
//   - capture=1 at edge N: shadow[i]<=acc_in[i] for all i; idx<=0; state<=DRAIN.
//   - acc_clear=1 for the cycle after edge N only.
//  DRAIN:
//   - out_valid=1, busy=1, out_index=idx, out_last=(idx==ARRAY_SIZE-1).
//   - out_data=sat(shadow[idx] >>> SHIFT).
//  Latency: capture sampled at edge N -> out_valid high in cycle N+1, lane 0 presented.
//  Handshake: a word transfers on a clk edge with out_valid&&out_ready.
//   - On transfer, not last: idx<=idx+1.
//   - On transfer, last: state<=IDLE, out_valid falls.
//   - While out_valid&&!out_ready: out_data, out_index and out_last hold stable.
//   - out_valid never drops without a transfer, except on reset.
//  Requantize:
//   - Arithmetic shift: sign-extending, floor rounding, no round-half.
//   - Saturate to [-2^(OUT-1), 2^(OUT-1)-1].
//   - With SHIFT=0 and OUT=ACC widths, the value passes unchanged.
//  Capture during DRAIN:
//   - Ignored; shadow is untouched; capture_dropped=1 next cycle; no acc_clear.
//   - Exception: capture on the same edge as the last-lane transfer is accepted
//     as a new snapshot. idx<=0, state stays DRAIN, acc_clear pulses, no bubble.
//  ARRAY_SIZE=1: every word has out_last=1; the drain lasts one transfer.
//  Reset mid-drain: all state returns to reset values immediately; no further words.
//  acc_in is sampled only on an accepted capture; changes at other times have no effect.
// TESTING (ARRAY_SIZE=2, ACC=16, OUT=8, SHIFT=2 unless noted)
//  1 acc_in={100,-20}, capture, out_ready=1
//    -> next cycle (25,idx0,last0); then (-5,idx1,last1).
//    -> busy falls after 2 words; acc_clear is a single pulse.
//  2 acc_in={1000,-1000}
//    -> outputs 127 then -128 (saturation).
//    -> acc_in={-1,-3} -> outputs -1 then -1 (floor).
//  3 out_ready=0 for 3 cycles after capture
//    -> out_valid=1 and out_data=25 held stable all 3 cycles; transfer on the 4th.
//  4 capture in the lane-0 cycle
//    -> capture_dropped pulses; drain still yields 25,-5.
//    -> capture on the last-transfer edge with acc_in={8,4}
//       -> next words 2,1 with no idle cycle.
//  5 assert rst while lane 0 is stalled
//    -> out_valid, busy, out_data and out_index all read 0 before the next edge.
//    -> after release, idle until the next capture.
//  6 ARRAY_SIZE=1, SHIFT=0, OUT=16, acc_in={-32768}
//    -> a single word -32768 with out_last=1.

Source files
------------

// File: rtl/mac_result_drain.sv
// Snapshots the mac_array accumulator vector on capture, then streams each lane
// out (arithmetic shift + signed saturation) over a valid/ready handshake.
module mac_result_drain #(
    parameter int ARRAY_SIZE             = 2,
    parameter int ACCUMULATOR_DATA_WIDTH = 16,
    parameter int OUT_DATA_WIDTH         = 8,
    parameter int SHIFT                  = 0,
    localparam int IW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         capture,
    input  logic [ARRAY_SIZE*ACCUMULATOR_DATA_WIDTH-1:0] acc_in,
    output logic                                         acc_clear,
    output logic                                         busy,
    output logic                                         capture_dropped,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [OUT_DATA_WIDTH-1:0]                    out_data,
    output logic [IW-1:0]                                out_index,
    output logic                                         out_last
);
    localparam int AW = ACCUMULATOR_DATA_WIDTH;
    localparam int OW = OUT_DATA_WIDTH;
    localparam logic [IW-1:0] LAST_IDX = IW'(ARRAY_SIZE - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    state_t                   state_r, state_s;
    logic [IW-1:0]            idx_r, idx_s;
    logic [ARRAY_SIZE*AW-1:0] shadow_r;
    logic                     accept_s, dropped_s, xfer_s;
    logic signed [AW-1:0]     lane_s;

    // Floor shift (sign-extending) followed by clamp to the output range.
    function automatic logic [OW-1:0] requant(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] sh;
        sh = v >>> SHIFT;
        if (sh > SAT_MAX) begin
            requant = SAT_MAX[OW-1:0];
        end else if (sh < SAT_MIN) begin
            requant = SAT_MIN[OW-1:0];
        end else begin
            requant = sh[OW-1:0];
        end
    endfunction

    // Next-state, lane index and the lane value to present next cycle.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        accept_s  = 1'b0;
        dropped_s = 1'b0;
        lane_s    = {AW{1'b0}};
        xfer_s    = (state_r == DRAIN) && out_ready;
        case (state_r)
            IDLE: begin
                if (capture) begin
                    accept_s = 1'b1;
                    idx_s    = {IW{1'b0}};
                    state_s  = DRAIN;
                end else begin
                    state_s  = IDLE;
                end
            end
            DRAIN: begin
                if (xfer_s && (idx_r == LAST_IDX)) begin
                    // A capture landing on the final transfer chains straight into a new drain.
                    if (capture) begin
                        accept_s = 1'b1;
                    end else begin
                        state_s  = IDLE;
                    end
                    idx_s = {IW{1'b0}};
                end else begin
                    if (xfer_s) begin
                        idx_s = idx_r + IW'(1);
                    end else begin
                        idx_s = idx_r;
                    end
                    dropped_s = capture;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = {IW{1'b0}};
            end
        endcase
        if (accept_s) begin
            lane_s = acc_in[AW-1:0];
        end else begin
            lane_s = shadow_r[idx_s*AW +: AW];
        end
    end

    // State, snapshot and registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            idx_r           <= {IW{1'b0}};
            shadow_r        <= {(ARRAY_SIZE*AW){1'b0}};
            out_valid       <= 1'b0;
            busy            <= 1'b0;
            acc_clear       <= 1'b0;
            capture_dropped <= 1'b0;
            out_index       <= {IW{1'b0}};
            out_last        <= 1'b0;
            out_data        <= {OW{1'b0}};
        end else begin
            state_r         <= state_s;
            idx_r           <= idx_s;
            if (accept_s) begin
                shadow_r <= acc_in;
            end
            out_valid       <= (state_s == DRAIN);
            busy            <= (state_s == DRAIN);
            acc_clear       <= accept_s;
            capture_dropped <= dropped_s;
            out_index       <= idx_s;
            out_last        <= (state_s == DRAIN) && (idx_s == LAST_IDX);
            out_data        <= (state_s == DRAIN) ? requant(lane_s) : {OW{1'b0}};
        end
    end
endmodule

// File: tb/tb_mac_result_drain.sv
// Scoreboard bench for mac_result_drain: a 2-lane SHIFT=2 instance and a
// 1-lane pass-through instance, directed vectors with hand-computed results.
module tb_mac_result_drain;
    typedef struct {int data; int idx; int last;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cap0 = 1'b0, rdy0 = 1'b0;
    logic [31:0] acc0 = 32'd0;
    logic        clr0, busy0, drop0, val0, last0;
    logic [7:0]  dat0;
    logic [0:0]  idx0;

    logic        cap1 = 1'b0, rdy1 = 1'b0;
    logic [15:0] acc1 = 16'd0;
    logic        clr1, busy1, drop1, val1, last1;
    logic [15:0] dat1;
    logic [0:0]  idx1;

    mac_result_drain #(.ARRAY_SIZE(2), .ACCUMULATOR_DATA_WIDTH(16), .OUT_DATA_WIDTH(8), .SHIFT(2)) u0 (
        .clk(clk), .rst(rst), .capture(cap0), .acc_in(acc0), .acc_clear(clr0), .busy(busy0),
        .capture_dropped(drop0), .out_valid(val0), .out_ready(rdy0), .out_data(dat0),
        .out_index(idx0), .out_last(last0));

    mac_result_drain #(.ARRAY_SIZE(1), .ACCUMULATOR_DATA_WIDTH(16), .OUT_DATA_WIDTH(16), .SHIFT(0)) u1 (
        .clk(clk), .rst(rst), .capture(cap1), .acc_in(acc1), .acc_clear(clr1), .busy(busy1),
        .capture_dropped(drop1), .out_valid(val1), .out_ready(rdy1), .out_data(dat1),
        .out_index(idx1), .out_last(last1));

    int   tests = 0;
    int   fails = 0;
    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [31:0] lanes(input int a, input int b);
        lanes = {16'(b), 16'(a)};
    endfunction

    task automatic push0(input int d, input int i, input int l);
        exp_t e;
        e.data = d; e.idx = i; e.last = l;
        q0.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && val0 && rdy0) begin
                if (q0.size() == 0) begin
                    chk("u0_unexpected_word", 1, 0);
                end else begin
                    e = q0.pop_front();
                    chk("u0_data", int'($signed(dat0)), e.data);
                    chk("u0_index", int'(idx0), e.idx);
                    chk("u0_last", int'(last0), e.last);
                end
            end
            if (!rst && val1 && rdy1) begin
                if (q1.size() == 0) begin
                    chk("u1_unexpected_word", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("u1_data", int'($signed(dat1)), e.data);
                    chk("u1_index", int'(idx1), e.idx);
                    chk("u1_last", int'(last1), e.last);
                end
            end
        end
    endtask

    task automatic stimulus();
        exp_t e;
        // reset state
        sample();
        chk("rst_valid", int'(val0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_data", int'(dat0), 0);
        chk("rst_index", int'(idx0), 0);
        chk("rst_clear", int'(clr0), 0);
        step();
        rst = 1'b0;
        step();

        // 1: basic drain
        acc0 = lanes(100, -20); cap0 = 1'b1; rdy0 = 1'b1;
        push0(25, 0, 0); push0(-5, 1, 1);
        step();
        cap0 = 1'b0;
        sample();
        chk("t1_clear_pulse", int'(clr0), 1);
        chk("t1_busy", int'(busy0), 1);
        step(); sample();
        chk("t1_clear_single", int'(clr0), 0);
        step(); sample();
        chk("t1_busy_fall", int'(busy0), 0);
        chk("t1_valid_fall", int'(val0), 0);

        // 2: saturation, then floor rounding
        acc0 = lanes(1000, -1000); cap0 = 1'b1;
        push0(127, 0, 0); push0(-128, 1, 1);
        step(); cap0 = 1'b0; step(); step();
        acc0 = lanes(-1, -3); cap0 = 1'b1;
        push0(-1, 0, 0); push0(-1, 1, 1);
        step(); cap0 = 1'b0; step(); step();

        // 3: back-pressure holds lane 0 stable
        acc0 = lanes(100, -20); cap0 = 1'b1; rdy0 = 1'b0;
        push0(25, 0, 0); push0(-5, 1, 1);
        step(); cap0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t3_hold_valid", int'(val0), 1);
            chk("t3_hold_data", int'($signed(dat0)), 25);
            chk("t3_hold_index", int'(idx0), 0);
            step();
        end
        rdy0 = 1'b1;
        step(); step(); step();

        // 4: dropped capture, then capture chained on the last transfer
        acc0 = lanes(100, -20); cap0 = 1'b1;
        push0(25, 0, 0); push0(-5, 1, 1);
        step();
        acc0 = lanes(50, 50);
        step();
        acc0 = lanes(8, 4);
        push0(2, 0, 0); push0(1, 1, 1);
        sample();
        chk("t4_dropped", int'(drop0), 1);
        chk("t4_no_clear", int'(clr0), 0);
        step(); cap0 = 1'b0;
        sample();
        chk("t4_chain_clear", int'(clr0), 1);
        chk("t4_no_bubble", int'(val0), 1);
        chk("t4_drop_single", int'(drop0), 0);
        step(); step(); step(); sample();
        chk("t4_idle", int'(busy0), 0);

        // 5: reset while lane 0 is stalled
        acc0 = lanes(100, -20); cap0 = 1'b1; rdy0 = 1'b0;
        step(); cap0 = 1'b0;
        sample();
        chk("t5_valid_before", int'(val0), 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_valid", int'(val0), 0);
        chk("t5_rst_busy", int'(busy0), 0);
        chk("t5_rst_data", int'(dat0), 0);
        chk("t5_rst_index", int'(idx0), 0);
        step(); step();
        rst = 1'b0; rdy0 = 1'b1;
        step(); step(); step(); sample();
        chk("t5_idle_valid", int'(val0), 0);
        chk("t5_idle_busy", int'(busy0), 0);

        // 6: single lane, full width pass-through
        acc1 = 16'h8000; cap1 = 1'b1; rdy1 = 1'b1;
        e.data = -32768; e.idx = 0; e.last = 1;
        q1.push_back(e);
        step(); cap1 = 1'b0;
        sample();
        chk("t6_last", int'(last1), 1);
        chk("t6_clear", int'(clr1), 1);
        step(); step(); sample();
        chk("t6_idle", int'(busy1), 0);

        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) begin
            step();
        end
        chk("scoreboard_drained", q0.size() + q1.size(), 0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
